dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 168 ++++++++++++++++
 tb/tb_dmem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data-memory responder with a valid/ready request/response handshake.
// It supports byte, half and word loads and stores over 4 byte lanes, with
// little-endian lane order. Illegal requests are answered with rsp_err and
// never touch the memory.

// One byte lane of storage. The read is asynchronous and the write is synchronous.
// The array has no reset, so its contents survive a reset.
module dmem_lane #(
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] idx,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    logic [7:0] ram [1<<AWIDTH];

    // Write the lane only when this lane is selected.
    always_ff @(posedge clk) begin
        if (we) ram[idx] <= wdata;
    end

    assign rdata = ram[idx];
endmodule

module dmem_responder #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [DWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    input  logic              isByte,
    input  logic              isHalf,
    input  logic              isWord,
    input  logic              isUnsigned,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int LANES = DWIDTH / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Only the byte-offset and word-index bits of the address are kept.
    // The upper bits only matter for the range check at acceptance.
    typedef struct packed {
        logic              wr;
        logic [AWIDTH+1:0] addr;
        logic [DWIDTH-1:0] wdata;
        logic              is_byte;
        logic              is_half;
        logic              is_word;
        logic              is_unsigned;
    } req_t;

    state_t state, state_nx;
    req_t   req_in, held;
    logic   accept, req_bad;

    logic [AWIDTH-1:0]     idx;
    logic [1:0]            off;
    logic [LANES-1:0]      lane_sel, lane_we;
    logic [LANES-1:0][7:0] wlane, rd_word;
    logic [7:0]            byte_val;
    logic [15:0]           half_val;
    logic [DWIDTH-1:0]     load_val;

    assign req_in = '{wr: req_wr, addr: req_addr[AWIDTH+1:0], wdata: req_wdata,
                      is_byte: isByte, is_half: isHalf, is_word: isWord,
                      is_unsigned: isUnsigned};
    assign accept = req_valid & req_ready;

    // The request is illegal if the size flags are not one-hot, the address is misaligned,
    // or the address falls beyond the storage.
    always_comb begin
        req_bad = (({1'b0, isByte} + {1'b0, isHalf} + {1'b0, isWord}) != 2'd1)
                | (isHalf & req_addr[0])
                | (isWord & (req_addr[1:0] != 2'b00))
                | (|req_addr[DWIDTH-1:AWIDTH+2]);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic. An error skips ACCESS and goes straight to RESP.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = req_bad ? RESP : ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs. req_ready is masked by reset so that it reads 0 while reset is held.
    always_comb begin
        req_ready = (state == IDLE) & reset;
        rsp_valid = (state == RESP);
    end

    // Capture the request at acceptance, so that later input changes cannot affect it.
    always_ff @(posedge clk) begin
        if (accept) held <= req_in;
    end

    assign idx = held.addr[AWIDTH+1:2];
    assign off = held.addr[1:0];

    // Lane selection, and store data replicated so that each lane sees its own byte.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_sel[i] = held.is_word
                        | (held.is_half & (off[1] == 1'(i / 2)))
                        | (held.is_byte & (off == 2'(i)));
        end
        lane_we = lane_sel & {LANES{(state == ACCESS) & held.wr & reset}};
        if (held.is_byte)      wlane = {LANES{held.wdata[7:0]}};
        else if (held.is_half) wlane = {(LANES/2){held.wdata[15:0]}};
        else                   wlane = held.wdata;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dmem_lane #(.AWIDTH(AWIDTH)) u_lane (
            .clk   (clk),
            .we    (lane_we[g]),
            .idx   (idx),
            .wdata (wlane[g]),
            .rdata (rd_word[g])
        );
    end

    // Align the load to bit 0 and extend it. A word load ignores isUnsigned.
    always_comb begin
        byte_val = rd_word[off];
        half_val = {rd_word[{off[1], 1'b1}], rd_word[{off[1], 1'b0}]};
        load_val = rd_word;
        if (held.is_byte)
            load_val = {{(DWIDTH-8){~held.is_unsigned & byte_val[7]}}, byte_val};
        else if (held.is_half)
            load_val = {{(DWIDTH-16){~held.is_unsigned & half_val[15]}}, half_val};
    end

    // Response registers. An error is resolved at acceptance, and data is resolved in ACCESS.
    // Both registers hold their values through RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_rdata <= '0;
            rsp_err   <= req_bad;
        end else if (state == ACCESS) begin
            rsp_rdata <= held.wr ? '0 : load_val;
            rsp_err   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. A byte-addressed little-endian memory model predicts
// every response. Directed scenarios are followed by a randomized request mix.
module tb_dmem_responder;
    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0, reset = 1'b0;
    logic          req_valid = 0, req_ready, req_wr = 0;
    logic [DW-1:0] req_addr = '0, req_wdata = '0;
    logic          isByte = 0, isHalf = 0, isWord = 0, isUnsigned = 0;
    logic          rsp_valid, rsp_ready = 0, rsp_err;
    logic [DW-1:0] rsp_rdata;

    int n_chk = 0, n_err = 0;
    logic [7:0] mb [0:4095];
    logic [31:0] got;

    always #5 clk = ~clk;

    dmem_responder #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .isByte(isByte), .isHalf(isHalf), .isWord(isWord), .isUnsigned(isUnsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [31:0] a, input bit b, h, w);
        return (int'(b) + int'(h) + int'(w) != 1) || (h && a[0]) ||
               (w && (a % 4 != 0)) || (a >= 32'd4096);
    endfunction

    // Run one complete transaction. The response is held for 'hold' cycles before it is taken.
    task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input bit b, h, w, u, input int hold, output logic [31:0] obs);
        bit e;
        logic [31:0] exp;
        e = model_err(a, b, h, w);
        exp = '0;
        if (!e && !wr) begin
            if (w) exp = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
            else if (h) begin
                exp = {16'h0, mb[a+1], mb[a]};
                if (!u && exp[15]) exp |= 32'hFFFF_0000;
            end else begin
                exp = {24'h0, mb[a]};
                if (!u && exp[7]) exp |= 32'hFFFF_FF00;
            end
        end
        if (!e && wr) begin
            int n;
            n = w ? 4 : (h ? 2 : 1);
            for (int k = 0; k < n; k++) mb[a+k] = d[8*k +: 8];
        end
        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 1);
        req_valid = 1; req_wr = wr; req_addr = a; req_wdata = d;
        isByte = b; isHalf = h; isWord = w; isUnsigned = u;
        @(posedge clk);
        #1;
        req_valid = 0; req_wr = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        isByte = 1'($urandom); isHalf = 1'($urandom); isWord = 1'($urandom);
        isUnsigned = 1'($urandom);
        @(negedge clk);
        chk("ready_busy", 32'(req_ready), 0);
        if (e) chk("err_latency", 32'(rsp_valid), 1);
        else begin
            chk("no_early_valid", 32'(rsp_valid), 0);
            @(negedge clk);
            chk("latency", 32'(rsp_valid), 1);
        end
        chk("rdata", rsp_rdata, exp);
        chk("err", 32'(rsp_err), 32'(e));
        obs = rsp_rdata;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_rdata", rsp_rdata, exp);
            chk("hold_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        @(negedge clk);
        chk("rsp_done", 32'(rsp_valid), 0);
        chk("back_idle", 32'(req_ready), 1);
    endtask

    initial begin
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", 32'(rsp_err), 0);
        repeat (3) @(negedge clk);
        reset = 1;
        #1 chk("ready_after_rst", 32'(req_ready), 1);

        // Initialise bytes 0..63 so that every later in-range load has defined data.
        for (int i = 0; i < 16; i++) txn(1, 32'(i * 4), $urandom, 0, 0, 1, 0, 0, got);

        // Word store, then word load.
        txn(1, 32'h10, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, got);
        txn(0, 32'h10, 0, 0, 0, 1, 0, 0, got);
        chk("word_load", got, 32'hDEAD_BEEF);
        // Byte lane, with signed and unsigned extension.
        txn(1, 32'h11, 32'h0000_0080, 1, 0, 0, 0, 0, got);
        txn(0, 32'h11, 0, 1, 0, 0, 0, 0, got);
        chk("byte_signed", got, 32'hFFFF_FF80);
        txn(0, 32'h11, 0, 1, 0, 0, 1, 0, got);
        chk("byte_unsigned", got, 32'h0000_0080);
        txn(0, 32'h10, 0, 0, 0, 1, 0, 0, got);
        chk("word_after_byte", got, 32'hDEAD_80EF);
        // Half access.
        txn(1, 32'h22, 32'h0000_1234, 0, 1, 0, 0, 0, got);
        txn(0, 32'h22, 0, 0, 1, 0, 0, 0, got);
        chk("half_signed", got, 32'h0000_1234);
        txn(0, 32'h20, 0, 0, 0, 1, 0, 0, got);
        chk("half_upper", got >> 16, 32'h0000_1234);
        // Error cases, including erroring stores that must leave memory untouched.
        txn(0, 32'h13, 0, 0, 0, 1, 0, 0, got);
        txn(0, 32'h21, 0, 0, 1, 0, 0, 0, got);
        txn(0, 32'h10, 0, 1, 1, 0, 0, 0, got);
        txn(0, 32'h1000, 0, 0, 0, 1, 0, 0, got);
        txn(1, 32'h13, 32'h5555_5555, 0, 0, 1, 0, 0, got);
        txn(1, 32'h1010, 32'h5555_5555, 0, 0, 1, 0, 0, got);
        txn(1, 32'h10, 32'h5555_5555, 0, 0, 0, 0, 0, got);
        txn(0, 32'h10, 0, 0, 0, 1, 0, 0, got);
        chk("mem_unchanged", got, 32'hDEAD_80EF);
        // Backpressure.
        txn(0, 32'h10, 0, 0, 0, 1, 0, 5, got);

        // Reset during ACCESS of a store: the write must not happen.
        txn(1, 32'h30, 32'h1111_1111, 0, 0, 1, 0, 0, got);
        @(negedge clk);
        req_valid = 1; req_wr = 1; req_addr = 32'h30; req_wdata = 32'hAAAA_AAAA;
        isByte = 0; isHalf = 0; isWord = 1; isUnsigned = 0;
        @(posedge clk);
        #2 reset = 0; req_valid = 0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        chk("mid_rst_rdata", rsp_rdata, 0);
        chk("mid_rst_err", 32'(rsp_err), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1;
        #1 chk("rst_release_ready", 32'(req_ready), 1);
        txn(0, 32'h30, 0, 0, 0, 1, 0, 0, got);
        chk("no_write_on_rst", got, 32'h1111_1111);

        // Reset while a response is pending: the response is dropped.
        @(negedge clk);
        req_valid = 1; req_wr = 0; req_addr = 32'h30;
        isByte = 0; isHalf = 0; isWord = 1;
        @(posedge clk);
        #1 req_valid = 0;
        repeat (2) @(negedge clk);
        chk("resp_pending", 32'(rsp_valid), 1);
        reset = 0;
        #1 chk("resp_discard", 32'(rsp_valid), 0);
        @(negedge clk);
        reset = 1;

        // Randomized mix of request types and addresses.
        for (int t = 0; t < 300; t++) begin
            bit wr, b, h, w;
            logic [31:0] a;
            int sel;
            wr = 1'($urandom);
            a = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 63));
            sel = $urandom_range(0, 9);
            if (sel == 0) {b, h, w} = 3'($urandom);
            else if (sel <= 3) {b, h, w} = 3'b100;
            else if (sel <= 6) {b, h, w} = 3'b010;
            else {b, h, w} = 3'b001;
            txn(wr, a, $urandom, b, h, w, 1'($urandom), $urandom_range(0, 3), got);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
